// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending denominations, encodings and payout states
//
// Purpose: denomination values and one-hot codes shared by the vending FSM
// (coin input) and the change dispenser, plus the dispenser state encoding.
// Denomination index order everywhere: 0=1, 1=5, 2=10, 3=20, 4=50.
package vend_pkg;

  localparam int NUM_DENOM = 5;

  localparam logic [7:0] DENOM_1  = 8'd1;
  localparam logic [7:0] DENOM_5  = 8'd5;
  localparam logic [7:0] DENOM_10 = 8'd10;
  localparam logic [7:0] DENOM_20 = 8'd20;
  localparam logic [7:0] DENOM_50 = 8'd50;

  localparam logic [NUM_DENOM-1:0] OH_1  = 5'b00001;
  localparam logic [NUM_DENOM-1:0] OH_5  = 5'b00010;
  localparam logic [NUM_DENOM-1:0] OH_10 = 5'b00100;
  localparam logic [NUM_DENOM-1:0] OH_20 = 5'b01000;
  localparam logic [NUM_DENOM-1:0] OH_50 = 5'b10000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } disp_state_t;

  function automatic logic [7:0] denom_value(input int idx);
    case (idx)
      0:       return DENOM_1;
      1:       return DENOM_5;
      2:       return DENOM_10;
      3:       return DENOM_20;
      4:       return DENOM_50;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [NUM_DENOM-1:0] denom_onehot(input int idx);
    case (idx)
      0:       return OH_1;
      1:       return OH_5;
      2:       return OH_10;
      3:       return OH_20;
      4:       return OH_50;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// rtl/change_dispense_ctrl_if.sv - dispense handshake between controller and mechanism
//
// Purpose: groups the per-item request/acknowledge handshake.
// Signals:
//   disp_req    level request, held until ack / timeout / abort
//   disp_denom  one-hot denomination while disp_req=1, 0 otherwise
//   disp_ack    mechanism has released the requested item
// Modports: master = controller, slave = mechanism.
interface change_dispense_ctrl_if;
  import vend_pkg::*;

  logic                 disp_req;
  logic [NUM_DENOM-1:0] disp_denom;
  logic                 disp_ack;

  modport master (
    output disp_req,
    output disp_denom,
    input  disp_ack
  );

  modport slave (
    input  disp_req,
    input  disp_denom,
    output disp_ack
  );

endinterface

// File: rtl/denom_picker.sv
// rtl/denom_picker.sv - greedy largest-first denomination selection
//
// Purpose: picks the largest denomination that fits the amount still owed
// and still has stock. Purely combinational, no back-tracking.
// Ports:
//   remaining   in   8  amount still owed
//   stock_nz    in   5  per-denomination "stock > 0" flags
//   sel_onehot  out  5  one-hot selected denomination (0 if none)
//   sel_value   out  8  value of the selected denomination (0 if none)
//   none_valid  out  1  no denomination qualifies
module denom_picker
  import vend_pkg::*;
(
  input  logic [7:0]           remaining,
  input  logic [NUM_DENOM-1:0] stock_nz,
  output logic [NUM_DENOM-1:0] sel_onehot,
  output logic [7:0]           sel_value,
  output logic                 none_valid
);

  // Ascending scan: a later (larger) qualifying denomination overwrites
  // a smaller one, so the largest candidate wins.
  always_comb begin
    sel_onehot = '0;
    sel_value  = '0;
    none_valid = 1'b1;
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (stock_nz[i] && (denom_value(i) <= remaining)) begin
        sel_onehot = denom_onehot(i);
        sel_value  = denom_value(i);
        none_valid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// rtl/change_dispense_ctrl.sv - change payout sequencer for the coin/note mechanism
//
// Purpose: pays out change_amount one item at a time, greedy largest-first
// over 50/20/10/5/1, limited by per-denomination stock counters, and reports
// done or fail back to the vending FSM.
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   start               pulse: latch change_amount and begin (IDLE only)
//   change_amount       8-bit amount to pay
//   abort               pulse: stop payout, report fail
//   refill              reload every stock to INIT_STOCK (IDLE only)
//   disp                dispense handshake (master side)
//   busy                high in every state except IDLE
//   done / fail         one-cycle outcome pulses
//   remaining           amount still owed
//   stock_sel           0..4 selects denomination 1,5,10,20,50; 5..7 read 0
//   stock_count         combinational readback of the selected stock
module change_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int INIT_STOCK  = 20,
  parameter int STOCK_W     = 6,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [7:0]            change_amount,
  input  logic                  abort,
  input  logic                  refill,
  change_dispense_ctrl_if.master disp,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [7:0]            remaining,
  input  logic [2:0]            stock_sel,
  output logic [STOCK_W-1:0]    stock_count
);

  // One counter serves both the ack timeout (REQ) and the inter-item gap (GAP).
  localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(INIT_STOCK);

  disp_state_t state, state_nx;

  logic [CNT_W-1:0]     cyc_cnt;
  logic [STOCK_W-1:0]   stock [NUM_DENOM];
  logic [NUM_DENOM-1:0] stock_nz;
  logic [NUM_DENOM-1:0] sel_oh_q;
  logic [7:0]           sel_val_q;

  logic [NUM_DENOM-1:0] pick_oh;
  logic [7:0]           pick_val;
  logic                 pick_none;
  logic                 take_item;

  always_comb begin
    for (int i = 0; i < NUM_DENOM; i++) begin
      stock_nz[i] = (stock[i] != '0);
    end
  end

  denom_picker u_picker (
    .remaining  (remaining),
    .stock_nz   (stock_nz),
    .sel_onehot (pick_oh),
    .sel_value  (pick_val),
    .none_valid (pick_none)
  );

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and outputs
  always_comb begin
    state_nx        = state;
    take_item       = 1'b0;
    busy            = (state != ST_IDLE);
    done            = (state == ST_DONE);
    fail            = (state == ST_FAIL);
    disp.disp_req   = (state == ST_REQ);
    disp.disp_denom = (state == ST_REQ) ? sel_oh_q : '0;

    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_SELECT;
      end
      ST_SELECT: begin
        if (remaining == 8'd0) state_nx = ST_DONE;
        else if (pick_none)    state_nx = ST_FAIL;
        else                   state_nx = ST_REQ;
      end
      ST_REQ: begin
        if (disp.disp_ack) begin
          take_item = 1'b1;
          state_nx  = ST_GAP;
        end else if (cyc_cnt == TMO_LAST) begin
          state_nx = ST_FAIL;
        end
      end
      ST_GAP: begin
        if (cyc_cnt == GAP_LAST) state_nx = ST_SELECT;
      end
      ST_DONE: state_nx = ST_IDLE;
      ST_FAIL: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase

    // Abort overrides the exit, but an item acked in the same cycle is
    // still accounted for through take_item.
    if (abort && (state != ST_IDLE)) state_nx = ST_FAIL;
  end

  // Cycle counter restarts on every state change.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cyc_cnt <= '0;
    end else if (state_nx != state) begin
      cyc_cnt <= '0;
    end else if (cyc_cnt != {CNT_W{1'b1}}) begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
    end
  end

  // Selection latch, amount owed and stock counters
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel_oh_q  <= '0;
      sel_val_q <= '0;
      remaining <= '0;
      for (int i = 0; i < NUM_DENOM; i++) begin
        stock[i] <= INIT_VAL;
      end
    end else begin
      if (state == ST_SELECT) begin
        sel_oh_q  <= pick_oh;
        sel_val_q <= pick_val;
      end

      if ((state == ST_IDLE) && start) begin
        remaining <= change_amount;
      end else if (take_item) begin
        // sel_val_q <= remaining was guaranteed by the picker.
        remaining <= remaining - sel_val_q;
      end

      for (int i = 0; i < NUM_DENOM; i++) begin
        if ((state == ST_IDLE) && refill) begin
          stock[i] <= INIT_VAL;
        end else if (take_item && sel_oh_q[i] && (stock[i] != '0)) begin
          stock[i] <= stock[i] - STOCK_W'(1);
        end
      end
    end
  end

  always_comb begin
    stock_count = '0;
    case (stock_sel)
      3'd0:    stock_count = stock[0];
      3'd1:    stock_count = stock[1];
      3'd2:    stock_count = stock[2];
      3'd3:    stock_count = stock[3];
      3'd4:    stock_count = stock[4];
      default: stock_count = '0;
    endcase
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// tb/tb_change_dispense_ctrl.sv - scoreboard bench for change_dispense_ctrl
module tb_change_dispense_ctrl;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  // Per-instance stimulus (driven by the main process) and observed outputs.
  // Instance 0: defaults; 1: INIT_STOCK=1; 2: TIMEOUT_CYC=16.
  logic       start_v  [3];
  logic [7:0] amt_v    [3];
  logic       abort_v  [3];
  logic       refill_v [3];
  logic       ack_en_v [3];
  logic [2:0] sel_v    [3];
  logic       busy_v   [3];
  logic       done_v   [3];
  logic       fail_v   [3];
  logic       req_v    [3];
  logic       ack_v    [3];
  logic [4:0] denom_v  [3];
  logic [7:0] rem_v    [3];
  logic [5:0] stk_v    [3];

  int exp_stk [3][5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  genvar g;
  for (g = 0; g < 3; g++) begin : gd
    change_dispense_ctrl_if dif ();
    logic       ack = 1'b0;
    int         acnt = 0;
    int         req_cyc = 0;
    logic       busy, done, fail;
    logic [7:0] rem;
    logic [5:0] stk;
    logic [4:0] exp_item [$];
    logic [8:0] exp_out  [$];

    assign dif.disp_ack = ack;
    assign busy_v[g]  = busy;
    assign done_v[g]  = done;
    assign fail_v[g]  = fail;
    assign req_v[g]   = dif.disp_req;
    assign ack_v[g]   = ack;
    assign denom_v[g] = dif.disp_denom;
    assign rem_v[g]   = rem;
    assign stk_v[g]   = stk;

    change_dispense_ctrl #(
      .INIT_STOCK  ((g == 1) ? 1 : 20),
      .STOCK_W     (6),
      .GAP_CYC     (4),
      .TIMEOUT_CYC ((g == 2) ? 16 : 1000)
    ) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .start         (start_v[g]),
      .change_amount (amt_v[g]),
      .abort         (abort_v[g]),
      .refill        (refill_v[g]),
      .disp          (dif),
      .busy          (busy),
      .done          (done),
      .fail          (fail),
      .remaining     (rem),
      .stock_sel     (sel_v[g]),
      .stock_count   (stk)
    );

    // Mechanism model: ack on the second falling edge of a request.
    always @(negedge sys_clk) begin
      if (!sys_rst_n || !dif.disp_req) begin
        ack  = 1'b0;
        acnt = 0;
      end else if (!ack && ack_en_v[g]) begin
        acnt++;
        if (acnt == 2) ack = 1'b1;
      end
    end

    // Monitor: items taken and outcome pulses against the scoreboard.
    always @(negedge sys_clk) begin
      #1;
      if (sys_rst_n) begin
        if (dif.disp_req) req_cyc++;
        if (dif.disp_req && ack) begin
          if (exp_item.size() == 0) check("item_unexpected", 1, 0);
          else check("item_denom", dif.disp_denom, exp_item.pop_front());
        end
        if (done || fail) begin
          if (exp_out.size() == 0) check("outcome_unexpected", 1, 0);
          else begin
            logic [8:0] e;
            e = exp_out.pop_front();
            check("outcome_kind", {fail, done}, e[8] ? 2'b10 : 2'b01);
            check("outcome_rem", rem, e[7:0]);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 5; i++) exp_stk[d][i] = (d == 1) ? 1 : 20;
  endtask

  task automatic push_item(input int d, input int idx);
    logic [4:0] oh;
    oh = 5'd1 << idx;
    case (d)
      0: gd[0].exp_item.push_back(oh);
      1: gd[1].exp_item.push_back(oh);
      2: gd[2].exp_item.push_back(oh);
      default: ;
    endcase
    exp_stk[d][idx]--;
  endtask

  task automatic push_out(input int d, input logic is_fail, input logic [7:0] r);
    case (d)
      0: gd[0].exp_out.push_back({is_fail, r});
      1: gd[1].exp_out.push_back({is_fail, r});
      2: gd[2].exp_out.push_back({is_fail, r});
      default: ;
    endcase
  endtask

  task automatic pulse_start(input int d, input logic [7:0] amt);
    start_v[d] = 1'b1;
    amt_v[d]   = amt;
    step(1);
    start_v[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (busy_v[d] && n < 3000) begin
      step(1);
      n++;
    end
    check("idle_wait", busy_v[d], 0);
  endtask

  task automatic check_stocks(input int d);
    for (int i = 0; i < 6; i++) begin
      sel_v[d] = 3'(i);
      step(1);
      if (i < 5) check("stock", stk_v[d], exp_stk[d][i]);
      else       check("stock_sel_hi", stk_v[d], 0);
    end
    sel_v[d] = 3'd0;
  endtask

  initial begin
    int r0;
    int acks;
    sys_rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 0; amt_v[d] = 0; abort_v[d] = 0;
      refill_v[d] = 0; ack_en_v[d] = 1; sel_v[d] = 0;
    end
    model_reset();
    step(2);
    for (int d = 0; d < 3; d++) begin
      check("rst_busy", busy_v[d], 0);
      check("rst_req", req_v[d], 0);
      check("rst_denom", denom_v[d], 0);
      check("rst_rem", rem_v[d], 0);
      check("rst_done", done_v[d], 0);
      check("rst_fail", fail_v[d], 0);
    end
    sys_rst_n = 1'b1;
    step(1);

    // 86 -> 50,20,10,5,1 then done
    for (int i = 4; i >= 0; i--) push_item(0, i);
    push_out(0, 1'b0, 8'd0);
    pulse_start(0, 8'd86);
    check("lat_select_busy", busy_v[0], 1);
    check("lat_select_req", req_v[0], 0);
    step(1);
    check("lat_req", req_v[0], 1);
    check("lat_denom", denom_v[0], 5'b10000);
    wait_idle(0);
    check("pay86_rem", rem_v[0], 0);
    check_stocks(0);

    // INIT_STOCK=1, 40 -> 20,10,5,1 then fail with 4 owed
    for (int i = 3; i >= 0; i--) push_item(1, i);
    push_out(1, 1'b1, 8'd4);
    pulse_start(1, 8'd40);
    wait_idle(1);
    check("nostock_rem", rem_v[1], 4);
    check_stocks(1);

    // TIMEOUT_CYC=16, never ack
    ack_en_v[2] = 1'b0;
    r0 = gd[2].req_cyc;
    push_out(2, 1'b1, 8'd5);
    pulse_start(2, 8'd5);
    wait_idle(2);
    check("tmo_req_cycles", gd[2].req_cyc - r0, 16);
    check("tmo_rem", rem_v[2], 5);
    check_stocks(2);

    // change 0: done after the second edge, no request
    r0 = gd[0].req_cyc;
    push_out(0, 1'b0, 8'd0);
    pulse_start(0, 8'd0);
    check("zero_busy", busy_v[0], 1);
    check("zero_done_early", done_v[0], 0);
    step(1);
    check("zero_done", done_v[0], 1);
    wait_idle(0);
    check("zero_no_req", gd[0].req_cyc - r0, 0);

    // 30 with a second start while busy (ignored)
    push_item(0, 3);
    push_item(0, 2);
    push_out(0, 1'b0, 8'd0);
    pulse_start(0, 8'd30);
    step(2);
    pulse_start(0, 8'd99);
    wait_idle(0);
    check("busy_start_rem", rem_v[0], 0);

    // 73: ack the 50, abort while the 20 is acked
    push_item(0, 4);
    push_item(0, 3);
    push_out(0, 1'b1, 8'd3);
    pulse_start(0, 8'd73);
    acks = 0;
    for (int n = 0; n < 200 && acks < 2; n++) begin
      if (ack_v[0]) begin
        acks++;
        if (acks == 2) abort_v[0] = 1'b1;
      end
      step(1);
      abort_v[0] = 1'b0;
    end
    check("abort_reached", acks, 2);
    wait_idle(0);
    check("abort_rem", rem_v[0], 3);
    check_stocks(0);

    refill_v[0] = 1'b1;
    step(1);
    refill_v[0] = 1'b0;
    for (int i = 0; i < 5; i++) exp_stk[0][i] = 20;
    check_stocks(0);

    // asynchronous reset in the middle of a request
    ack_en_v[0] = 1'b0;
    pulse_start(0, 8'd50);
    step(1);
    check("pre_rst_req", req_v[0], 1);
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_req", req_v[0], 0);
    check("async_rst_denom", denom_v[0], 0);
    check("async_rst_busy", busy_v[0], 0);
    step(2);
    sys_rst_n = 1'b1;
    model_reset();
    step(1);
    check("post_rst_busy", busy_v[0], 0);
    check("post_rst_rem", rem_v[0], 0);
    check_stocks(0);
    check_stocks(1);

    check("left_items0", gd[0].exp_item.size(), 0);
    check("left_items1", gd[1].exp_item.size(), 0);
    check("left_out0", gd[0].exp_out.size(), 0);
    check("left_out1", gd[1].exp_out.size(), 0);
    check("left_out2", gd[2].exp_out.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
Sequences the coin/note output mechanism that pays out change once a vending transaction settles. It takes the 8-bit change amount from the vending state machine and issues one dispense request per item: greedy largest-first over denominations 50/20/10/5/1, limited by an internal per-denomination stock count. It handshakes each item with the mechanism and reports done or fail back to the vending FSM, which displays the result.

Parameters:
INIT_STOCK, 20, stock count loaded per denomination at reset and on refill
STOCK_W, 6, width of each stock counter (INIT_STOCK < 2**STOCK_W)
GAP_CYC, 4, idle cycles with disp_req low between consecutive items
TIMEOUT_CYC, 1000, maximum cycles waiting for disp_ack before failing

Ports:
sys_clk  in  1  system clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; latch change_amount and begin payout (ignored unless IDLE)
change_amount  in  8  change to pay, unsigned units
abort  in  1  single-cycle pulse; stop payout
refill  in  1  reload all stocks to INIT_STOCK (honoured only in IDLE)
disp_ack  in  1  mechanism has released the requested item
disp_req  out  1  dispense request, level, held until ack/timeout/abort
disp_denom  out  5  one-hot denomination while disp_req=1: bit4=50, bit3=20, bit2=10, bit1=5, bit0=1; 0 otherwise
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: remaining reached 0
fail  out  1  one-cycle pulse: no stock, timeout, or abort
remaining  out  8  change still owed
stock_sel  in  3  0..4 selects denomination 1,5,10,20,50 for readback; 5..7 read 0
stock_count  out  STOCK_W  combinational readback of selected stock

Behaviour:
- Reset (async): state=IDLE; disp_req=0, disp_denom=0, busy=0, done=0, fail=0, remaining=0; all stocks=INIT_STOCK; counters=0. disp_req drops immediately on reset assertion.
- States: IDLE, SELECT, REQ, GAP, DONE, FAIL.
- IDLE: start -> remaining<=change_amount, go to SELECT. refill -> stocks<=INIT_STOCK. If start and refill arrive together, do both.
- SELECT (1 cycle): remaining==0 -> DONE. Otherwise pick the largest d in {50,20,10,5,1} with d<=remaining and stock[d]>0, then go to REQ with disp_denom=onehot(d). If no d qualifies -> FAIL. Greedy only: no back-tracking search.
- REQ: disp_req=1 and disp_denom are stable until exit. The timeout counter increments each cycle.
  - disp_ack sampled high: stock[d]-=1, remaining-=d, go to GAP.
  - Counter reaches TIMEOUT_CYC-1 with no ack: go to FAIL; stock and remaining unchanged.
- GAP: disp_req=0 for GAP_CYC cycles, then SELECT.
- DONE / FAIL: 1 cycle, pulsing done/fail respectively, then IDLE. remaining is held (0 after DONE; the unpaid amount after FAIL).
- abort in any non-IDLE state: next state FAIL. If disp_ack is high in the same cycle in REQ, the item counts first (stock and remaining updated), then FAIL.
- start while busy: ignored. refill while busy: ignored. disp_ack outside REQ: ignored.
- Latency: start sampled at edge k -> SELECT after k; disp_req=1 after edge k+1. change_amount=0 -> done pulse after edge k+1, no request issued.
- Arithmetic: the subtraction cannot underflow because d<=remaining is checked. A stock at 0 is never decremented.

Decomposition:
- Shared package vend_pkg: denomination values (1,5,10,20,50), 5-bit one-hot encodings, state encodings. The vending FSM reuses the denomination constants for coin input.
- One sub-module, denom_picker: combinational. Inputs are remaining and five stock-nonzero flags; outputs are a one-hot select, its value, and a none-valid flag.

Test Plan:
- Default params, start change=86, ack 2 cycles after each req -> items 50,20,10,5,1 in order, done pulse, remaining=0, every stock reads 19.
- INIT_STOCK=1, start change=40 -> items 20,10,5,1, then fail pulse with remaining=4; stock for denominations 20/10/5/1 reads 0, stock for 50 reads 1.
- TIMEOUT_CYC=16, start change=5, never ack -> disp_req high exactly 16 cycles, fail pulse, remaining=5, stock for 5 unchanged at 20.
- start change=0 -> done pulse after second edge, disp_req never asserted. start pulsed again while busy on change=30 -> ignored, payout of 30 completes normally.
- start change=73, ack the 50, assert abort during the next REQ with disp_ack high -> the 20 counted, fail pulse, remaining=3. refill in IDLE -> all stocks=20.
- Assert sys_rst_n=0 mid-REQ -> disp_req=0 without waiting for a clock edge. After release: IDLE, all stocks=INIT_STOCK, busy=0.
